// File: rtl/tara_media_saturada.sv
// Tare unit: subtracts a captured/averaged tare from raw samples and registers
// a saturated signed net weight, one cycle after each valid sample.
module tara_media_saturada #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_TARE = 50,
  parameter int AVG_LOG2     = 2
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] entrada,
  input  logic             in_valid,
  input  logic             tare_req,
  input  logic             tare_clr,
  output logic [WIDTH-1:0] resultado,
  output logic             out_valid,
  output logic             sat,
  output logic             negativo,
  output logic             busy,
  output logic [WIDTH-1:0] tara
);
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0]         LAST     = CW'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0]      DEF_TARE = WIDTH'(DEFAULT_TARE);
  localparam logic signed [WIDTH:0] MAXV     = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] MINV     = {2'b11, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state_q;
  logic [AW-1:0]     acc_q, acc_sum;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  tara_q, tara_avg;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              sat_q, sat_d, neg_q, neg_d, vld_q, busy_q;
  logic signed [WIDTH:0] diff;

  always_comb begin
    diff  = $signed({1'b0, entrada}) - $signed({1'b0, tara_q});
    res_d = diff[WIDTH-1:0];
    sat_d = 1'b0;
    neg_d = diff[WIDTH];
    if (diff > MAXV) begin
      res_d = MAXV[WIDTH-1:0];
      sat_d = 1'b1;
    end else if (diff < MINV) begin
      res_d = MINV[WIDTH-1:0];
      sat_d = 1'b1;
    end
    // Accumulator is wide enough that the final sum never wraps.
    acc_sum  = acc_q + AW'(entrada);
    tara_avg = acc_sum[AW-1:AVG_LOG2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tara_q  <= DEF_TARE;
      res_q   <= '0;
      sat_q   <= 1'b0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
        sat_q <= sat_d;
        neg_q <= neg_d;
      end
      // Clear overrides both a new request and a completing capture.
      if (tare_clr) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        tara_q  <= DEF_TARE;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (tare_req) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
          CAPTURE: if (in_valid) begin
            if (cnt_q == LAST) begin
              tara_q  <= tara_avg;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign resultado = res_q;
  assign out_valid = vld_q;
  assign sat       = sat_q;
  assign negativo  = neg_q;
  assign busy      = busy_q;
  assign tara      = tara_q;
endmodule
